// File: rtl/logic_pod_phase_shift_arbiter.sv
// Round-robin arbiter that shares one MMCM dynamic phase-shift port among NUM_PODS
// pod alignment controllers, tracking the net signed shift and flagging protocol errors.
module logic_pod_phase_shift_arbiter #(
   parameter int NUM_PODS       = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                clk_312p5mhz,
   input  logic                rst_n,
   input  logic [NUM_PODS-1:0] req_en,
   input  logic [NUM_PODS-1:0] req_inc,
   output logic [NUM_PODS-1:0] req_done,
   output logic                psen,
   output logic                psincdec,
   input  logic                psdone,
   output logic [15:0]         phase_pos,
   output logic                err_timeout,
   output logic [NUM_PODS-1:0] err_overrun
);

   localparam int IDX_W = $clog2(NUM_PODS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_PODS-1:0] pending_q, pending_d;
   logic [NUM_PODS-1:0] dir_q, dir_d;
   logic [NUM_PODS-1:0] req_done_q, req_done_d;
   logic [NUM_PODS-1:0] err_overrun_q, err_overrun_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                psincdec_q, psincdec_d;
   logic                err_timeout_q, err_timeout_d;
   logic [15:0]         timer_q, timer_d;
   logic [15:0]         phase_pos_q, phase_pos_d;

   logic [NUM_PODS-1:0] busy;
   logic [NUM_PODS-1:0] accept;
   logic                found;
   logic [IDX_W-1:0]    pick;
   int                  idx;

   // A requester is busy while pending or while it owns the port (ISSUE/WAIT).
   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_PODS; i++) begin
         busy[i] = pending_q[i] | ((state_q != ST_IDLE) && (grant_q == IDX_W'(i)));
      end
   end

   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_PODS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_PODS) begin
            idx = idx - NUM_PODS;
         end
         if (!found && pending_q[IDX_W'(idx)]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      psincdec_d    = psincdec_q;
      timer_d       = timer_q;
      phase_pos_d   = phase_pos_q;
      err_timeout_d = err_timeout_q;
      req_done_d    = '0;
      accept        = req_en & ~busy;
      err_overrun_d = err_overrun_q | (req_en & busy);
      pending_d     = pending_q | accept;
      dir_d         = (dir_q & ~accept) | (req_inc & accept);

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               pending_d[pick] = 1'b0;
               grant_d         = pick;
               psincdec_d      = dir_q[pick];
               rr_ptr_d        = (pick == IDX_W'(NUM_PODS - 1)) ? '0 : pick + 1'b1;
               state_d         = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (psdone) begin
               req_done_d[grant_q] = 1'b1;
               phase_pos_d         = psincdec_q ? phase_pos_q + 16'd1 : phase_pos_q - 16'd1;
               state_d             = ST_IDLE;
            end else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
               err_timeout_d       = 1'b1;
               req_done_d[grant_q] = 1'b1;
               state_d             = ST_IDLE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_312p5mhz) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pending_q     <= '0;
         dir_q         <= '0;
         req_done_q    <= '0;
         err_overrun_q <= '0;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         psincdec_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         timer_q       <= '0;
         phase_pos_q   <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         dir_q         <= dir_d;
         req_done_q    <= req_done_d;
         err_overrun_q <= err_overrun_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         psincdec_q    <= psincdec_d;
         err_timeout_q <= err_timeout_d;
         timer_q       <= timer_d;
         phase_pos_q   <= phase_pos_d;
      end
   end

   assign psen        = (state_q == ST_ISSUE);
   assign psincdec    = psincdec_q;
   assign req_done    = req_done_q;
   assign phase_pos   = phase_pos_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_logic_pod_phase_shift_arbiter.sv
// Directed bench for the phase-shift arbiter: an MMCM model answers psen after a fixed
// latency, and a monitor logs every psen and req_done for comparison with hand-computed results.
module tb_logic_pod_phase_shift_arbiter;

   localparam int PS_LAT = 12;

   logic       clk_312p5mhz = 1'b0;
   logic       rst_n;
   logic [3:0] req_en;
   logic [3:0] req_inc;
   logic [3:0] req_done;
   logic       psen;
   logic       psincdec;
   logic       psdone;
   logic [15:0] phase_pos;
   logic       err_timeout;
   logic [3:0] err_overrun;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mmcm_respond = 1'b1;

   int         psen_cyc[$];
   logic       psen_dir[$];
   logic [3:0] done_vec[$];
   int         done_cyc[$];

   logic_pod_phase_shift_arbiter #(.NUM_PODS(4), .TIMEOUT_CYCLES(1023)) dut (
      .clk_312p5mhz (clk_312p5mhz),
      .rst_n        (rst_n),
      .req_en       (req_en),
      .req_inc      (req_inc),
      .req_done     (req_done),
      .psen         (psen),
      .psincdec     (psincdec),
      .psdone       (psdone),
      .phase_pos    (phase_pos),
      .err_timeout  (err_timeout),
      .err_overrun  (err_overrun)
   );

   always #2 clk_312p5mhz = ~clk_312p5mhz;

   // MMCM model: psdone pulses PS_LAT cycles after the cycle psen is seen high.
   initial begin
      psdone = 1'b0;
      forever begin
         @(posedge clk_312p5mhz);
         #1;
         if (psen === 1'b1 && mmcm_respond) begin
            repeat (PS_LAT) @(posedge clk_312p5mhz);
            #1 psdone = 1'b1;
            @(posedge clk_312p5mhz);
            #1 psdone = 1'b0;
         end
      end
   end

   // Monitor logs psen/req_done events with the cycle they appeared in.
   initial begin
      forever begin
         @(posedge clk_312p5mhz);
         #1;
         cyc++;
         if (psen === 1'b1) begin
            psen_dir.push_back(psincdec);
            psen_cyc.push_back(cyc);
         end
         if (req_done !== 4'b0000) begin
            done_vec.push_back(req_done);
            done_cyc.push_back(cyc);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic clearLogs();
      psen_cyc.delete();
      psen_dir.delete();
      done_vec.delete();
      done_cyc.delete();
   endtask

   task automatic applyReset();
      @(negedge clk_312p5mhz);
      rst_n   = 1'b0;
      req_en  = '0;
      req_inc = '0;
      @(negedge clk_312p5mhz);
      rst_n = 1'b1;
      clearLogs();
   endtask

   task automatic applyStimulus(input logic [3:0] en, input logic [3:0] inc);
      @(negedge clk_312p5mhz);
      req_en  = en;
      req_inc = inc;
      @(negedge clk_312p5mhz);
      req_en  = '0;
   endtask

   task automatic waitDones(input string tag, input int n, input int budget);
      for (int c = 0; c < budget && done_vec.size() < n; c++) begin
         @(negedge clk_312p5mhz);
      end
      checkOutput(tag, done_vec.size(), n);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk_312p5mhz);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed simulation still running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit seen;
      rst_n   = 1'b0;
      req_en  = '0;
      req_inc = '0;
      repeat (3) @(negedge clk_312p5mhz);
      rst_n = 1'b1;
      clearLogs();

      checkOutput("rst_psen", psen, 0);
      checkOutput("rst_psincdec", psincdec, 0);
      checkOutput("rst_req_done", req_done, 0);
      checkOutput("rst_phase_pos", phase_pos, 0);
      checkOutput("rst_err_timeout", err_timeout, 0);
      checkOutput("rst_err_overrun", err_overrun, 0);

      $display("[TB] single increment request on pod 0");
      applyStimulus(4'b0001, 4'b0001);
      waitDones("single_wait", 1, 100);
      idleCycles(20);
      checkOutput("single_psen_count", psen_dir.size(), 1);
      checkOutput("single_psincdec", psen_dir[0], 1);
      checkOutput("single_done_count", done_vec.size(), 1);
      checkOutput("single_done_pod", done_vec[0], 4'b0001);
      checkOutput("single_latency", done_cyc[0] - psen_cyc[0], PS_LAT + 1);
      checkOutput("single_phase_pos", phase_pos, 16'd1);

      $display("[TB] contention on all pods");
      applyReset();
      applyStimulus(4'b1111, 4'b0101);
      waitDones("cont_wait", 4, 200);
      idleCycles(20);
      checkOutput("cont_psen_count", psen_dir.size(), 4);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] onehot;
         logic [3:0] pattern;
         onehot  = 4'b0001 << i;
         pattern = 4'b0101;
         checkOutput($sformatf("cont_done_%0d", i), done_vec[i], onehot);
         checkOutput($sformatf("cont_dir_%0d", i), psen_dir[i], pattern[i]);
      end
      checkOutput("cont_phase_pos", phase_pos, 16'd0);
      checkOutput("cont_overrun", err_overrun, 0);

      $display("[TB] fairness with pod 0 re-requesting on its req_done");
      applyReset();
      applyStimulus(4'b1111, 4'b1111);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk_312p5mhz);
         if (req_done[0] === 1'b1) seen = 1'b1;
      end
      checkOutput("fair_first_done0", seen, 1);
      req_en  = 4'b0001;
      req_inc = 4'b0001;
      @(negedge clk_312p5mhz);
      req_en  = '0;
      waitDones("fair_wait", 5, 300);
      idleCycles(20);
      begin
         logic [3:0] order [5];
         order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("fair_done_%0d", i), done_vec[i], order[i]);
         end
      end
      checkOutput("fair_psen_count", psen_dir.size(), 5);
      checkOutput("fair_phase_pos", phase_pos, 16'd5);
      checkOutput("fair_no_overrun", err_overrun, 0);

      $display("[TB] timeout with psdone withheld");
      applyReset();
      mmcm_respond = 1'b0;
      applyStimulus(4'b0010, 4'b0010);
      waitDones("tmo_wait", 1, 1300);
      mmcm_respond = 1'b1;
      checkOutput("tmo_done_pod", done_vec[0], 4'b0010);
      checkOutput("tmo_latency", done_cyc[0] - psen_cyc[0], 1024);
      checkOutput("tmo_err_timeout", err_timeout, 1);
      checkOutput("tmo_phase_pos", phase_pos, 16'd0);
      applyStimulus(4'b1000, 4'b0000);
      waitDones("tmo_next_wait", 2, 100);
      idleCycles(5);
      checkOutput("tmo_next_done_pod", done_vec[1], 4'b1000);
      checkOutput("tmo_next_phase_pos", phase_pos, 16'hFFFF);
      checkOutput("tmo_sticky", err_timeout, 1);

      $display("[TB] overrun on pod 2");
      applyReset();
      applyStimulus(4'b0100, 4'b0100);
      applyStimulus(4'b0100, 4'b0000);
      idleCycles(4);
      applyStimulus(4'b0100, 4'b0000);
      waitDones("ovr_wait", 1, 100);
      idleCycles(20);
      checkOutput("ovr_err_overrun", err_overrun, 4'b0100);
      checkOutput("ovr_psen_count", psen_dir.size(), 1);
      checkOutput("ovr_psincdec", psen_dir[0], 1);
      checkOutput("ovr_done_count", done_vec.size(), 1);
      checkOutput("ovr_phase_pos", phase_pos, 16'd1);

      $display("[TB] reset during WAIT followed by a late psdone");
      applyReset();
      applyStimulus(4'b0010, 4'b0010);
      for (int c = 0; c < 20 && psen_dir.size() < 1; c++) begin
         @(negedge clk_312p5mhz);
      end
      checkOutput("rstw_psen_seen", psen_dir.size(), 1);
      idleCycles(3);
      rst_n = 1'b0;
      @(negedge clk_312p5mhz);
      rst_n = 1'b1;
      idleCycles(20);
      checkOutput("rstw_no_done", done_vec.size(), 0);
      checkOutput("rstw_phase_pos", phase_pos, 16'd0);
      checkOutput("rstw_psen_count", psen_dir.size(), 1);
      checkOutput("rstw_err_timeout", err_timeout, 0);
      applyStimulus(4'b0100, 4'b0000);
      waitDones("rstw_next_wait", 1, 100);
      checkOutput("rstw_next_done_pod", done_vec[0], 4'b0100);
      checkOutput("rstw_next_phase_pos", phase_pos, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/logic_pod_phase_shift_arbiter.md
LOGIC_POD_PHASE_SHIFT_ARBITER -- requirements
Module: logic_pod_phase_shift_arbiter

Interface
REQ-001 Parameter NUM_PODS, default 4, meaning number of requesters (pod phase-alignment controllers) sharing one MMCM dynamic phase-shift port; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, meaning maximum clocks to wait for psdone after psen before aborting; legal range 16..65535.
REQ-003 clk_312p5mhz  input  1  sole clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_en  input  NUM_PODS  per-requester one-cycle shift request pulse.
REQ-006 req_inc  input  NUM_PODS  per-requester direction, 1 = increment, sampled with req_en.
REQ-007 req_done  output  NUM_PODS  per-requester one-cycle completion pulse.
REQ-008 psen  output  1  MMCM phase-shift enable, one-cycle pulse.
REQ-009 psincdec  output  1  MMCM direction, valid while psen high and held until psdone.
REQ-010 psdone  input  1  MMCM completion pulse.
REQ-011 phase_pos  output  16  signed net shift count, two's complement.
REQ-012 err_timeout  output  1  sticky, psdone not seen within TIMEOUT_CYCLES.
REQ-013 err_overrun  output  NUM_PODS  sticky, new req_en while that requester already pending or in service.

Function
REQ-014 Each requester has a pending bit and latched direction; req_en sets pending and captures req_inc the same edge.
REQ-015 req_en on a requester already pending or in service is dropped (direction unchanged) and sets its err_overrun bit.
REQ-016 State machine: IDLE, ISSUE, WAIT.
REQ-017 IDLE: if any pending bit set, select requester by round-robin starting at (last granted + 1) mod NUM_PODS, clear its pending bit, go ISSUE; after reset the search starts at index 0.
REQ-018 ISSUE: assert psen for exactly one cycle with psincdec = granted direction, clear timeout counter, go WAIT.
REQ-019 WAIT: on psdone, pulse req_done[granted] next cycle, update phase_pos by +1 (inc) or -1 (dec) with 16-bit wrap, go IDLE.
REQ-020 WAIT: if counter reaches TIMEOUT_CYCLES without psdone, set err_timeout, pulse req_done[granted], leave phase_pos unchanged, go IDLE.
REQ-021 psdone outside WAIT is ignored.
REQ-022 Minimum service time per request: psen-to-psdone latency plus 2 cycles; arbiter never issues a second psen before the previous psdone or timeout.
REQ-023 A requester may re-request in the cycle its req_done is high; this is accepted, not an overrun.
REQ-024 req_en arriving the same cycle its requester is granted is an overrun.
REQ-025 Round-robin guarantees each pending requester service within NUM_PODS grants.

Reset
REQ-026 rst_n low on a clock edge: state IDLE, all pending bits 0, psen 0, psincdec 0, req_done 0, phase_pos 0, err_timeout 0, err_overrun 0, round-robin pointer to index 0.
REQ-027 Reset mid-WAIT abandons the outstanding shift with no req_done; a late psdone after reset is ignored.
REQ-028 Error flags clear only by reset.

Verification
REQ-029 Single: req_en[0]=1, req_inc[0]=1; MMCM model psdone 12 cycles after psen -> one psen, psincdec=1, req_done[0] once, phase_pos=1.
REQ-030 Contention: req_en=4'b1111 same cycle, req_inc=4'b0101 -> psen order pods 0,1,2,3, psincdec 1,0,1,0, phase_pos=0 at end, one req_done each.
REQ-031 Fairness: pod 0 re-requests on every req_done while pods 1..3 pending -> grants 0,1,2,3,0; no pod waits more than 4 grants.
REQ-032 Timeout: psdone withheld -> err_timeout=1 after 1023 WAIT cycles, req_done pulses, phase_pos unchanged, next request serviced.
REQ-033 Overrun: req_en[2] twice while pending -> err_overrun=4'b0100, exactly one shift for pod 2.
REQ-034 Reset mid-WAIT then late psdone -> no req_done, phase_pos=0, state IDLE.
